// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: shared types for the streaming channel multiplexer
package mux_stream_pkg;
   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;
endpackage

// File: rtl/mux_stream_rr_picker.sv
// rr_picker: picks the nearest requester after ptr, wrapping modulo NCH
module rr_picker #(
   parameter int NCH  = 4,
   parameter int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);
   int j;
   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      j = 0;
      for (int k = NCH; k >= 1; k--) begin
         j = (int'(ptr) + k) % NCH;
         if (req[j]) begin
            gnt_idx = SELW'(j);
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_stream.sv
// mux_stream: N-channel valid/ready mux with explicit or round-robin select
module mux_stream
   import mux_stream_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [NCH-1:0]     in_valid,
   input  logic [NCH*W-1:0]   in_data,
   output logic [NCH-1:0]     in_ready,
   output logic               out_valid,
   output logic [W-1:0]       out_data,
   output logic [SELW-1:0]    out_ch,
   input  logic               out_ready
);
   logic                  out_valid_q, out_valid_d;
   logic [W-1:0]          out_data_q, out_data_d;
   logic [SELW-1:0]       out_ch_q, out_ch_d;
   logic [SELW-1:0]       ptr_q, ptr_d;
   logic [SELW-1:0]       rr_idx, gnt;
   logic                  rr_any, gnt_ok, load_en, xfer, is_rr;
   logic [2**SELW-1:0]    valid_pad;

   rr_picker #(.NCH(NCH), .SELW(SELW)) u_picker (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   // Zero-padding makes an out-of-range sel read as "not valid" instead of X.
   always_comb begin
      is_rr       = (mode == MODE_RR);
      valid_pad   = (2**SELW)'(in_valid);
      load_en     = !out_valid_q || out_ready;
      gnt         = is_rr ? rr_idx : sel;
      gnt_ok      = is_rr ? rr_any : (int'(sel) < NCH) && valid_pad[sel];
      in_ready    = (rst_n && load_en && gnt_ok) ? NCH'(1) << gnt : '0;
      xfer        = |(in_valid & in_ready);
      out_valid_d = xfer || (out_valid_q && !out_ready);
      out_data_d  = xfer ? in_data[int'(gnt)*W +: W] : out_data_q;
      out_ch_d    = xfer ? gnt : out_ch_q;
      ptr_d       = (xfer && is_rr) ? gnt : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= SELW'(NCH-1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_mux_stream.sv
// tb_mux_stream: directed scoreboard bench for mux_stream and rr_picker
module tb_mux_stream;
   logic        clk = 1'b0;
   logic        rst_n, mode, out_ready, out_valid;
   logic [1:0]  sel, out_ch;
   logic [3:0]  in_valid, in_ready;
   logic [31:0] in_data;
   logic [7:0]  out_data;

   logic        t3_rst_n, t3_mode, t3_out_ready, t3_out_valid;
   logic [1:0]  t3_sel, t3_out_ch;
   logic [2:0]  t3_in_valid, t3_in_ready;
   logic [23:0] t3_in_data;
   logic [7:0]  t3_out_data;

   logic [4:0]  pk_req;
   logic [2:0]  pk_ptr, pk_idx;
   logic        pk_any;

   int          n_cmp = 0, n_bad = 0;
   int          m_ptr = 3;
   logic        m_valid = 1'b0;
   logic [9:0]  sb[$];

   always #5 clk = ~clk;

   mux_stream #(.NCH(4), .W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
   );

   mux_stream #(.NCH(3), .W(8)) dut3 (
      .clk(clk), .rst_n(t3_rst_n), .mode(t3_mode), .sel(t3_sel), .in_valid(t3_in_valid),
      .in_data(t3_in_data), .in_ready(t3_in_ready), .out_valid(t3_out_valid),
      .out_data(t3_out_data), .out_ch(t3_out_ch), .out_ready(t3_out_ready)
   );

   rr_picker #(.NCH(5), .SELW(3)) u_pk (
      .req(pk_req), .ptr(pk_ptr), .gnt_idx(pk_idx), .gnt_any(pk_any)
   );

   function automatic int rr_model(input int nch, input int ptr, input logic [7:0] req);
      for (int d = 1; d <= nch; d++)
         if (req[(ptr + d) % nch]) return (ptr + d) % nch;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of the 4-channel DUT: predict grant, check, score, advance.
   task automatic tick();
      int g;
      logic ok, xfer;
      logic [3:0] er;
      logic [9:0] e;
      #1;
      if (mode) begin
         g  = rr_model(4, m_ptr, {4'b0, in_valid});
         ok = (g >= 0);
      end else begin
         g  = int'(sel);
         ok = in_valid[sel];
      end
      er = (rst_n && (!m_valid || out_ready) && ok) ? 4'(1 << g) : 4'b0;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            e = sb.pop_front();
            chk("sb_data", 32'(out_data), 32'(e[7:0]));
            chk("sb_ch", 32'(out_ch), 32'(e[9:8]));
         end
      end
      xfer = |(er & in_valid);
      if (xfer) sb.push_back({2'(g), in_data[g*8 +: 8]});
      if (!rst_n) begin
         m_valid = 1'b0;
         m_ptr   = 3;
         sb.delete();
      end else begin
         m_valid = xfer || (m_valid && !out_ready);
         if (xfer && mode) m_ptr = g;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int r;
      rst_n = 1'b0; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
      in_valid = 4'b1111; in_data = 32'h0;
      t3_rst_n = 1'b0; t3_mode = 1'b0; t3_sel = 2'd0; t3_out_ready = 1'b1;
      t3_in_valid = 3'b000; t3_in_data = 24'h0;
      pk_req = 5'b0; pk_ptr = 3'd0;
      @(posedge clk);
      #1;
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = $urandom;
         tick();
         chk("rr_seq_ch", 32'(out_ch), 32'(i % 4));
         chk("rr_seq_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 4'b0000;
      tick();
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000;
      #1;
      chk("sel2_ready", 32'(in_ready), 32'h4);
      tick();
      chk("sel2_data", 32'(out_data), 32'hA5);
      chk("sel2_ch", 32'(out_ch), 32'd2);
      out_ready = 1'b0; in_data = 32'h005A_0000;
      repeat (4) begin
         tick();
         chk("stall_data", 32'(out_data), 32'hA5);
         chk("stall_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("drain_load_data", 32'(out_data), 32'h5A);
      chk("drain_load_valid", 32'(out_valid), 32'd1);
      mode = 1'b1; in_valid = 4'b0010; in_data = $urandom;
      tick();
      chk("skip_ptr1", 32'(out_ch), 32'd1);
      in_valid = 4'b1010;
      in_data = $urandom; tick(); chk("skip_a", 32'(out_ch), 32'd3);
      in_data = $urandom; tick(); chk("skip_b", 32'(out_ch), 32'd1);
      in_data = $urandom; tick(); chk("skip_c", 32'(out_ch), 32'd3);
      out_ready = 1'b0; in_valid = 4'b0000;
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", 32'(out_data), 32'd0);
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; in_data = $urandom;
      tick();
      chk("midrst_first_ch", 32'(out_ch), 32'd0);
      in_valid = 4'b0000;
      repeat (2) tick();

      t3_in_valid = 3'b111;
      @(posedge clk);
      #1;
      chk("t3_rst_ready", 32'(t3_in_ready), 32'd0);
      chk("t3_rst_valid", 32'(t3_out_valid), 32'd0);
      t3_rst_n = 1'b1; t3_sel = 2'd3; t3_in_data = 24'h33_22_11;
      #1;
      chk("t3_sel3_ready", 32'(t3_in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("t3_sel3_noxfer", 32'(t3_out_valid), 32'd0);
      t3_sel = 2'd1;
      #1;
      chk("t3_sel1_ready", 32'(t3_in_ready), 32'h2);
      @(posedge clk);
      #1;
      chk("t3_sel1_data", 32'(t3_out_data), 32'h22);
      chk("t3_sel1_ch", 32'(t3_out_ch), 32'd1);
      t3_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("t3_rr_ch", 32'(t3_out_ch), 32'(i % 3));
      end

      for (int i = 0; i < 40; i++) begin
         pk_req = 5'($urandom);
         pk_ptr = 3'($urandom_range(0, 4));
         #1;
         r = rr_model(5, int'(pk_ptr), {3'b0, pk_req});
         chk("pk_any", 32'(pk_any), 32'(r >= 0));
         if (r >= 0) chk("pk_idx", 32'(pk_idx), 32'(r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
